// File: rtl/multicycle_control_if.sv
// Datapath control bundle between the multicycle controller and its datapath.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       Opcode;
  logic             MemReady;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic             PCSource;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             Illegal;
  logic [3:0]       State;
  logic [CNT_W-1:0] Instret;

  // Datapath side: supplies opcode and memory completion, consumes controls.
  modport master (
    output Opcode, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
    input  RegWrite, ALUSrcA, PCSource, ALUSrcB, ALUOp, Illegal, State, Instret
  );

  // Controller side.
  modport slave (
    input  Opcode, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
    output RegWrite, ALUSrcA, PCSource, ALUSrcB, ALUOp, Illegal, State, Instret
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV-style control FSM with retired-instruction counter.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_control_if.slave bus
);
  localparam int unsigned ST_W = 4;
  localparam int unsigned OP_W = 7;

  localparam logic [ST_W-1:0] S_FETCH    = 4'd0;
  localparam logic [ST_W-1:0] S_DECODE   = 4'd1;
  localparam logic [ST_W-1:0] S_MEMADR   = 4'd2;
  localparam logic [ST_W-1:0] S_MEMREAD  = 4'd3;
  localparam logic [ST_W-1:0] S_MEMWB    = 4'd4;
  localparam logic [ST_W-1:0] S_MEMWRITE = 4'd5;
  localparam logic [ST_W-1:0] S_EXECUTE  = 4'd6;
  localparam logic [ST_W-1:0] S_ALUWB    = 4'd7;
  localparam logic [ST_W-1:0] S_BRANCH   = 4'd8;

  localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, alu_src_a, pc_source, illegal, retire;
  logic [1:0] alu_src_b, alu_op;

  // State and retired-instruction counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next-state, retirement and Moore/MemReady-qualified control decode.
  always_comb begin
    state_d       = state_q;
    instret_d     = instret_q;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    pc_source     = 1'b0;
    illegal       = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.MemReady;
        pc_write  = bus.MemReady;
        if (bus.MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (bus.Opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTE;
          OP_BEQ:            state_d = S_BRANCH;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.Opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus.MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (bus.MemReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (retire) instret_d = instret_q + CNT_W'(1);
  end

  // Controls are held inactive while reset is asserted.
  always_comb begin
    bus.PCWrite     = rst_n & pc_write;
    bus.PCWriteCond = rst_n & pc_write_cond;
    bus.IorD        = rst_n & i_or_d;
    bus.MemRead     = rst_n & mem_read;
    bus.MemWrite    = rst_n & mem_write;
    bus.IRWrite     = rst_n & ir_write;
    bus.MemtoReg    = rst_n & mem_to_reg;
    bus.RegWrite    = rst_n & reg_write;
    bus.ALUSrcA     = rst_n & alu_src_a;
    bus.PCSource    = rst_n & pc_source;
    bus.Illegal     = rst_n & illegal;
    bus.ALUSrcB     = rst_n ? alu_src_b : 2'b00;
    bus.ALUOp       = rst_n ? alu_op : 2'b00;
    bus.State       = state_q;
    bus.Instret     = instret_q;
  end
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control (32-bit and 4-bit counter builds).
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) bus ();
  multicycle_control_if #(.CNT_W(4))  bus4 ();

  multicycle_control #(.CNT_W(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  multicycle_control #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    logic [3:0]  st;
    logic [14:0] ctl;
    logic [31:0] ir;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] instret_m = 32'd0;

  logic [14:0] ctl32, ctl4;
  assign ctl32 = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.IRWrite, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.PCSource,
                  bus.ALUSrcB, bus.ALUOp, bus.Illegal};
  assign ctl4  = {bus4.PCWrite, bus4.PCWriteCond, bus4.IorD, bus4.MemRead, bus4.MemWrite,
                  bus4.IRWrite, bus4.MemtoReg, bus4.RegWrite, bus4.ALUSrcA, bus4.PCSource,
                  bus4.ALUSrcB, bus4.ALUOp, bus4.Illegal};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected controls for each state, straight from the per-state rules.
  function automatic logic [14:0] mk(input int st, input logic mr, input logic ill);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, asa, pcs;
    logic [1:0] asb, aop;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, asa, pcs} = 10'd0;
    asb = 2'b00;
    aop = 2'b00;
    case (st)
      0: begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
      1: asb = 2'b11;
      2: begin asa = 1'b1; asb = 2'b10; end
      3: begin mrd = 1'b1; iord = 1'b1; end
      4: begin rw = 1'b1; m2r = 1'b1; end
      5: begin mwr = 1'b1; iord = 1'b1; end
      6: begin asa = 1'b1; aop = 2'b10; end
      7: rw = 1'b1;
      8: begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 1'b1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, asa, pcs, asb, aop, ill};
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom());
  endfunction

  function automatic logic rnd_mr();
    return 1'($urandom());
  endfunction

  // One clock of stimulus; the expected view of that cycle is queued for the monitor.
  task automatic cyc(input logic [6:0] op, input logic mr, input logic [3:0] st,
                     input logic [14:0] c, input bit retire);
    exp_t e;
    bus.Opcode    = op;
    bus4.Opcode   = op;
    bus.MemReady  = mr;
    bus4.MemReady = mr;
    e.st  = st;
    e.ctl = rst_n ? c : 15'd0;
    e.ir  = instret_m;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!rst_n) instret_m = 32'd0;
    else if (retire) instret_m = instret_m + 32'd1;
  endtask

  // One instruction: 0=R-type 1=load 2=store 3=beq 4=illegal.
  task automatic run_instr(input int kind, input int fw, input int mw, input logic [6:0] ill_op);
    logic m;
    for (int i = 0; i < fw; i++) cyc(rnd_op(), 1'b0, 4'd0, mk(0, 1'b0, 1'b0), 1'b0);
    cyc(rnd_op(), 1'b1, 4'd0, mk(0, 1'b1, 1'b0), 1'b0);
    m = rnd_mr();
    case (kind)
      0: begin
        cyc(7'b0110011, m, 4'd1, mk(1, m, 1'b0), 1'b0);
        cyc(rnd_op(), rnd_mr(), 4'd6, mk(6, 1'b0, 1'b0), 1'b0);
        cyc(rnd_op(), rnd_mr(), 4'd7, mk(7, 1'b0, 1'b0), 1'b1);
      end
      1: begin
        cyc(7'b0000011, m, 4'd1, mk(1, m, 1'b0), 1'b0);
        cyc(7'b0000011, rnd_mr(), 4'd2, mk(2, 1'b0, 1'b0), 1'b0);
        for (int i = 0; i < mw; i++) cyc(rnd_op(), 1'b0, 4'd3, mk(3, 1'b0, 1'b0), 1'b0);
        cyc(rnd_op(), 1'b1, 4'd3, mk(3, 1'b1, 1'b0), 1'b0);
        cyc(rnd_op(), rnd_mr(), 4'd4, mk(4, 1'b0, 1'b0), 1'b1);
      end
      2: begin
        cyc(7'b0100011, m, 4'd1, mk(1, m, 1'b0), 1'b0);
        cyc(7'b0100011, rnd_mr(), 4'd2, mk(2, 1'b0, 1'b0), 1'b0);
        for (int i = 0; i < mw; i++) cyc(rnd_op(), 1'b0, 4'd5, mk(5, 1'b0, 1'b0), 1'b0);
        cyc(rnd_op(), 1'b1, 4'd5, mk(5, 1'b1, 1'b0), 1'b1);
      end
      3: begin
        cyc(7'b1100011, m, 4'd1, mk(1, m, 1'b0), 1'b0);
        cyc(rnd_op(), rnd_mr(), 4'd8, mk(8, 1'b0, 1'b0), 1'b1);
      end
      default: cyc(ill_op, m, 4'd1, mk(1, m, 1'b1), 1'b0);
    endcase
  endtask

  function automatic logic [6:0] rnd_illegal();
    logic [6:0] o;
    do o = rnd_op();
    while (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 || o == 7'b1100011);
    return o;
  endfunction

  // Monitor: compare both builds against the queued expectation every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("state", 32'(bus.State), 32'(e.st));
      chk("ctl", 32'(ctl32), 32'(e.ctl));
      chk("instret", bus.Instret, e.ir);
      chk("state4", 32'(bus4.State), 32'(e.st));
      chk("ctl4", 32'(ctl4), 32'(e.ctl));
      chk("instret4", 32'(bus4.Instret), 32'(e.ir[3:0]));
      chk("rd_wr_excl", 32'(bus.MemRead & bus.MemWrite), 32'd0);
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.Opcode = 7'd0;  bus4.Opcode = 7'd0;
    bus.MemReady = 1'b0; bus4.MemReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(rnd_op(), 1'b1, 4'd0, 15'd0, 1'b0);
    rst_n = 1'b1;

    // Directed: R-type, load with two MEMREAD waits, store, beq, illegal.
    run_instr(0, 0, 0, 7'd0);
    run_instr(1, 0, 2, 7'd0);
    run_instr(2, 0, 0, 7'd0);
    run_instr(3, 0, 0, 7'd0);
    run_instr(4, 0, 0, 7'b1111111);

    // Reset asserted while a store is waiting on memory.
    cyc(rnd_op(), 1'b1, 4'd0, mk(0, 1'b1, 1'b0), 1'b0);
    cyc(7'b0100011, 1'b1, 4'd1, mk(1, 1'b1, 1'b0), 1'b0);
    cyc(7'b0100011, 1'b1, 4'd2, mk(2, 1'b0, 1'b0), 1'b0);
    cyc(rnd_op(), 1'b0, 4'd5, mk(5, 1'b0, 1'b0), 1'b0);
    rst_n = 1'b0;
    cyc(rnd_op(), 1'b0, 4'd5, mk(5, 1'b0, 1'b0), 1'b0);
    cyc(rnd_op(), 1'b1, 4'd0, mk(0, 1'b1, 1'b0), 1'b0);
    rst_n = 1'b1;

    // Random mix; enough retirements to wrap the 4-bit counter more than once.
    for (int n = 0; n < 60; n++) begin
      int k;
      k = int'($urandom_range(0, 4));
      run_instr(k, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rnd_illegal());
    end

    @(posedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
